// File: rtl/ball_motion_ctrl.sv
// Bouncing-ball position controller: steps the ball one pixel per axis per update, paced by frame ticks.
// Optional BALL_CTRL_STEP_EN adds a 'step' input for single updates while stopped.
module ball_motion_ctrl #(
  parameter int X_MAX  = 640,
  parameter int Y_MAX  = 480,
  parameter int RADIUS = 100,
  parameter int X0     = 320,
  parameter int Y0     = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       run,
  input  logic [2:0] speed,
`ifdef BALL_CTRL_STEP_EN
  input  logic       step,
`endif
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic       bounce,
  output logic       update_done
);

  localparam logic [9:0] X_HI = 10'(X_MAX - RADIUS);
  localparam logic [9:0] Y_HI = 10'(Y_MAX - RADIUS);
  localparam logic [9:0] LO   = 10'(RADIUS);
  localparam logic [9:0] X_RST = 10'(X0);
  localparam logic [9:0] Y_RST = 10'(Y0);

  typedef enum logic [2:0] {IDLE, WAIT, MOVE_X, MOVE_Y, DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] div_cnt_q, div_cnt_d;
  logic [9:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic       flip_x_q, flip_x_d;
  logic       bounce_q, bounce_d;
  logic       update_done_q, update_done_d;
  logic       flip_y;
`ifdef BALL_CTRL_STEP_EN
  logic       step_prev_q, step_prev_d;
  logic       step_mode_q, step_mode_d;
  logic       step_rise;
  assign step_rise = step & ~step_prev_q;
`endif

  always_comb begin
    state_d       = state_q;
    div_cnt_d     = div_cnt_q;
    ball_x_d      = ball_x_q;
    ball_y_d      = ball_y_q;
    dir_x_d       = dir_x_q;
    dir_y_d       = dir_y_q;
    flip_x_d      = flip_x_q;
    flip_y        = 1'b0;
    bounce_d      = 1'b0;
    update_done_d = 1'b0;
`ifdef BALL_CTRL_STEP_EN
    step_prev_d   = step;
    step_mode_d   = step_mode_q;
`endif
    case (state_q)
      IDLE: begin
        div_cnt_d = 3'd0;
        if (run) begin
          state_d = WAIT;
        end
`ifdef BALL_CTRL_STEP_EN
        else if (step_rise) begin
          state_d     = MOVE_X;
          step_mode_d = 1'b1;
        end
`endif
      end
      WAIT: begin
        if (!run) begin
          state_d = IDLE;
        end else if (frame_tick) begin
          // '>=' so a speed lowered below the running count fires on the next tick
          if (div_cnt_q >= speed) begin
            div_cnt_d = 3'd0;
            state_d   = MOVE_X;
          end else begin
            div_cnt_d = div_cnt_q + 3'd1;
          end
        end
      end
      MOVE_X: begin
        flip_x_d = 1'b0;
        if (dir_x_q && ball_x_q >= X_HI) begin
          dir_x_d  = 1'b0;
          ball_x_d = ball_x_q - 10'd1;
          flip_x_d = 1'b1;
        end else if (!dir_x_q && ball_x_q <= LO) begin
          dir_x_d  = 1'b1;
          ball_x_d = ball_x_q + 10'd1;
          flip_x_d = 1'b1;
        end else begin
          ball_x_d = dir_x_q ? ball_x_q + 10'd1 : ball_x_q - 10'd1;
        end
        state_d = MOVE_Y;
      end
      MOVE_Y: begin
        if (dir_y_q && ball_y_q >= Y_HI) begin
          dir_y_d  = 1'b0;
          ball_y_d = ball_y_q - 10'd1;
          flip_y   = 1'b1;
        end else if (!dir_y_q && ball_y_q <= LO) begin
          dir_y_d  = 1'b1;
          ball_y_d = ball_y_q + 10'd1;
          flip_y   = 1'b1;
        end else begin
          ball_y_d = dir_y_q ? ball_y_q + 10'd1 : ball_y_q - 10'd1;
        end
        bounce_d      = flip_x_q | flip_y;
        update_done_d = 1'b1;
        state_d       = DONE;
      end
      DONE: begin
`ifdef BALL_CTRL_STEP_EN
        state_d     = step_mode_q ? IDLE : WAIT;
        step_mode_d = 1'b0;
`else
        state_d = WAIT;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      div_cnt_q     <= 3'd0;
      ball_x_q      <= X_RST;
      ball_y_q      <= Y_RST;
      dir_x_q       <= 1'b1;
      dir_y_q       <= 1'b1;
      flip_x_q      <= 1'b0;
      bounce_q      <= 1'b0;
      update_done_q <= 1'b0;
`ifdef BALL_CTRL_STEP_EN
      step_prev_q   <= 1'b0;
      step_mode_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      ball_x_q      <= ball_x_d;
      ball_y_q      <= ball_y_d;
      dir_x_q       <= dir_x_d;
      dir_y_q       <= dir_y_d;
      flip_x_q      <= flip_x_d;
      bounce_q      <= bounce_d;
      update_done_q <= update_done_d;
`ifdef BALL_CTRL_STEP_EN
      step_prev_q   <= step_prev_d;
      step_mode_q   <= step_mode_d;
`endif
    end
  end

  assign ball_x      = ball_x_q;
  assign ball_y      = ball_y_q;
  assign dir_x       = dir_x_q;
  assign dir_y       = dir_y_q;
  assign bounce      = bounce_q;
  assign update_done = update_done_q;

endmodule
